stop_it_ctrl: RTL and testbench
===============================

// Module: stop_it_ctrl
// PURPOSE
//   Game controller for the Stop-It round: sequences the external free-running time counter
//   (clear / enable / freeze), latches the player's target, judges the stop press and
//   holds the win/lose result.
//   Sits between the debounced button inputs and the time counter on the 4 Hz game clock.
// PARAMETERS
//   CountWidth    5    width of count_i and target_i
//   TimeoutCount  31   count value that ends RUN as a loss if stop has not been pressed
//   HoldCycles    8    cycles WIN/LOSE is held before returning to IDLE (2 s at 4 Hz)
// PORTS
//   clk_4_i       in   1           4 Hz game clock; all logic on posedge
//   rst_ni        in   1           asynchronous active-low reset
//   start_i       in   1           start button, already synchronised and debounced, level
//   stop_i        in   1           stop button, already synchronised and debounced, level
//   target_i      in   CountWidth  target count; sampled in CLEAR only
//   count_i       in   CountWidth  current value of the time counter
//   count_en_o    out  1           enable to the time counter
//   count_clr_no  out  1           active-low synchronous clear to the time counter
//   state_o       out  3           IDLE=0 CLEAR=1 RUN=2 WIN=3 LOSE=4
//   win_o         out  1           high throughout WIN
//   lose_o        out  1           high throughout LOSE
//   score_o       out  4           consecutive-win streak (see CONFIGURATION)
// BEHAVIOUR
//   - Reset: state IDLE, count_en_o=0, count_clr_no=0, win_o=0, lose_o=0, score_o=0,
//     target_q=0, hold counter=0. Edge-detect history flops reset to 1, so a button held
//     through reset does not produce a press.
//   - Press = rising edge: level high this cycle, low in the previous cycle (1-cycle pulse).
//   - IDLE: clr asserted, en=0. Start press -> CLEAR. Stop presses are ignored.
//   - CLEAR (exactly 1 cycle): clr asserted, en=0, target_q <= target_i -> RUN.
//   - RUN: clr deasserted; count_en_o = !stop_press (combinational), so the counter
//     freezes on the compared value. Start presses are ignored.
//     * Stop press: count_i==target_q -> WIN, else -> LOSE.
//     * Else count_i==TimeoutCount -> LOSE.
//     * Stop press and timeout in the same cycle: the stop compare wins (it is judged).
//   - WIN / LOSE: en=0, clr deasserted (frozen count remains displayed); hold counter
//     runs 0..HoldCycles-1, then -> IDLE. Entry cycle counts as cycle 0, so the state
//     lasts exactly HoldCycles cycles. All presses are ignored.
//   - win_o / lose_o are decoded from the registered state; they have no glitches.
//   - Compare is full CountWidth equality; no tolerance window.
//   - Async reset mid-round returns to the reset values immediately. The counter is
//     cleared on the first clock edge after reset release (clr is asserted in IDLE).
// CONFIGURATION
//   STOP_IT_SCORE_EN defined:
//     - On entry to WIN: score_o increments, saturating at 15.
//     - On entry to LOSE: score_o clears to 0.
//     - Otherwise score_o holds; reset clears it to 0.
//   STOP_IT_SCORE_EN undefined: score_o is tied to 4'd0 and no score flops exist.
// TESTING
//   1. Reset with start_i held high, then release rst_ni.
//      -> stays IDLE, no CLEAR, count_clr_no=0.
//   2. target_i=5; start press; stop press when count_i=5.
//      -> CLEAR 1 cycle, RUN; count_en_o=0 in the stop cycle; WIN for 8 cycles; IDLE.
//   3. target_i=5; stop press when count_i=7.
//      -> LOSE for 8 cycles; score_o=0 (SCORE_EN); count stays frozen at 7.
//   4. No stop press in RUN.
//      -> LOSE on the cycle count_i=31; stop press at count_i=31 with target 31 -> WIN.
//   5. target_i changed during RUN; start/stop pressed during WIN and IDLE.
//      -> judged against the latched target; the extra presses are ignored.
//   6. With STOP_IT_SCORE_EN: 17 consecutive wins -> score_o saturates at 15;
//      one loss -> 0. Also assert rst_ni low during RUN -> IDLE with all outputs at reset.

Source files
------------

// File: rtl/stop_it_ctrl_if.sv
// Signal bundle between the Stop-It game controller and its surroundings
// (debounced buttons, target switches, time counter, display/result outputs).
interface stop_it_ctrl_if #(
  parameter int CountWidth = 5
);
  logic                  start_i;
  logic                  stop_i;
  logic [CountWidth-1:0] target_i;
  logic [CountWidth-1:0] count_i;
  logic                  count_en_o;
  logic                  count_clr_no;
  logic [2:0]            state_o;
  logic                  win_o;
  logic                  lose_o;
  logic [3:0]            score_o;

  modport slave (
    input  start_i, stop_i, target_i, count_i,
    output count_en_o, count_clr_no, state_o, win_o, lose_o, score_o
  );

  modport master (
    output start_i, stop_i, target_i, count_i,
    input  count_en_o, count_clr_no, state_o, win_o, lose_o, score_o
  );
endinterface

// File: rtl/stop_it_ctrl.sv
// Stop-It round controller: sequences the time counter, latches the target and judges the stop press.
// Optional win-streak score counter is built only when STOP_IT_SCORE_EN is defined.
module stop_it_ctrl #(
  parameter int CountWidth   = 5,
  parameter int TimeoutCount = 31,
  parameter int HoldCycles   = 8
) (
  input  logic           clk_4_i,
  input  logic           rst_ni,
  stop_it_ctrl_if.slave  bus
);

  // state  | meaning
  // IDLE   | counter held in clear, waiting for a start press
  // CLEAR  | one cycle: counter still cleared, target latched
  // RUN    | counter running, waiting for stop press or timeout
  // WIN    | stop matched the target; result held HoldCycles cycles
  // LOSE   | mismatch or timeout; result held HoldCycles cycles
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_WIN   = 3'd3,
    ST_LOSE  = 3'd4
  } state_e;

  localparam int HoldW = (HoldCycles > 1) ? $clog2(HoldCycles) : 1;
  localparam logic [HoldW-1:0]      HoldLast   = HoldW'(HoldCycles - 1);
  localparam logic [CountWidth-1:0] TimeoutVal = CountWidth'(TimeoutCount);

  state_e                state_q;
  logic                  start_q;
  logic                  stop_q;
  logic                  run_q;
  logic                  clr_nq;
  logic [CountWidth-1:0] target_q;
  logic [HoldW-1:0]      hold_q;

  logic start_press;
  logic stop_press;
  logic hit;
  logic timeout;
  logic enter_win;
  logic enter_lose;

  assign start_press = bus.start_i & ~start_q;
  assign stop_press  = bus.stop_i & ~stop_q;
  assign hit         = (bus.count_i == target_q);
  assign timeout     = (bus.count_i == TimeoutVal);

  // A stop press is always judged, even when it coincides with the timeout value.
  assign enter_win  = (state_q == ST_RUN) && stop_press && hit;
  assign enter_lose = (state_q == ST_RUN) && ((stop_press && !hit) || (!stop_press && timeout));

  always_ff @(posedge clk_4_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      start_q  <= 1'b1;
      stop_q   <= 1'b1;
      run_q    <= 1'b0;
      clr_nq   <= 1'b0;
      target_q <= '0;
      hold_q   <= '0;
    end else begin
      start_q <= bus.start_i;
      stop_q  <= bus.stop_i;
      case (state_q)
        ST_IDLE: begin
          if (start_press) begin
            state_q <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          target_q <= bus.target_i;
          state_q  <= ST_RUN;
          run_q    <= 1'b1;
          clr_nq   <= 1'b1;
        end
        ST_RUN: begin
          if (enter_win) begin
            state_q <= ST_WIN;
            run_q   <= 1'b0;
            hold_q  <= '0;
          end else if (enter_lose) begin
            state_q <= ST_LOSE;
            run_q   <= 1'b0;
            hold_q  <= '0;
          end
        end
        ST_WIN, ST_LOSE: begin
          if (hold_q == HoldLast) begin
            state_q <= ST_IDLE;
            clr_nq  <= 1'b0;
            hold_q  <= '0;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          run_q   <= 1'b0;
          clr_nq  <= 1'b0;
          hold_q  <= '0;
        end
      endcase
    end
  end

  // Enable drops in the stop cycle itself so the counter freezes on the judged value.
  assign bus.count_en_o   = run_q & ~stop_press;
  assign bus.count_clr_no = clr_nq;
  assign bus.state_o      = state_q;
  assign bus.win_o        = (state_q == ST_WIN);
  assign bus.lose_o       = (state_q == ST_LOSE);

`ifdef STOP_IT_SCORE_EN
  logic [3:0] score_q;
  logic [3:0] score_d;

  always_comb begin
    score_d = score_q;
    if (enter_win && (score_q != 4'd15)) begin
      score_d = score_q + 4'd1;
    end else if (enter_lose) begin
      score_d = 4'd0;
    end
  end

  always_ff @(posedge clk_4_i or negedge rst_ni) begin
    if (!rst_ni) begin
      score_q <= 4'd0;
    end else begin
      score_q <= score_d;
    end
  end

  assign bus.score_o = score_q;
`else
  assign bus.score_o = 4'd0;
`endif

endmodule

// File: tb/tb_stop_it_ctrl.sv
// Scoreboard bench for stop_it_ctrl: a time-counter model closes the loop; rounds push expected
// state transitions which a negedge monitor pops and checks. Score expectations follow STOP_IT_SCORE_EN.
module tb_stop_it_ctrl;
  localparam int ST_IDLE = 0, ST_CLEAR = 1, ST_RUN = 2, ST_WIN = 3, ST_LOSE = 4;
  localparam int TO = 31;
  localparam int HOLD = 8;

  typedef struct {
    int st;
    int dur;
    int cnt;
    int score;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] cnt = '0;
  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  int exp_score = 0;

  stop_it_ctrl_if #(.CountWidth(5)) bus ();

  stop_it_ctrl dut (
    .clk_4_i (clk),
    .rst_ni  (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Time counter model: synchronous active-low clear, enable, 5-bit wrap.
  always @(posedge clk) begin
    if (!bus.count_clr_no) cnt <= '0;
    else if (bus.count_en_o) cnt <= cnt + 5'd1;
  end
  assign bus.count_i = cnt;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int st, input int dur, input int c, input int sc);
    exp_t e;
    e.st = st; e.dur = dur; e.cnt = c; e.score = sc;
    sb.push_back(e);
  endtask

  // Monitor: every state change is an output event checked against the scoreboard head.
  initial begin
    int prev;
    int dur;
    exp_t e;
    prev = ST_IDLE;
    dur = 0;
    forever begin
      @(negedge clk);
      if (int'(bus.state_o) != prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_transition", int'(bus.state_o), prev);
        end else begin
          e = sb.pop_front();
          chk("state", int'(bus.state_o), e.st);
          if (e.dur >= 0) chk("prev_state_duration", dur, e.dur);
          chk("win_o", int'(bus.win_o), int'(e.st == ST_WIN));
          chk("lose_o", int'(bus.lose_o), int'(e.st == ST_LOSE));
          chk("score_o", int'(bus.score_o), e.score);
          if (e.cnt >= 0) chk("count_frozen", int'(bus.count_i), e.cnt);
        end
        prev = int'(bus.state_o);
        dur = 1;
      end else begin
        dur++;
      end
    end
  end

  task automatic wait_state(input int s, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (int'(bus.state_o) == s) ok = 1;
    end
    if (!ok) chk("wait_state_timeout", int'(bus.state_o), s);
  endtask

  task automatic wait_cnt(input int v, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (int'(cnt) == v) ok = 1;
      else @(negedge clk);
    end
    if (!ok) chk("wait_count_timeout", int'(cnt), v);
  endtask

  // One round; stop_at < 0 means never press stop (timeout).
  task automatic play(input int tg, input int stop_at, input int tg_chg, input bit noise);
    bit w;
    int run_dur;
    w = (stop_at >= 0) && (stop_at == tg);
    run_dur = (stop_at >= 0) ? stop_at + 1 : TO + 1;
    push(ST_CLEAR, -1, 0, exp_score);
    push(ST_RUN, 1, 0, exp_score);
`ifdef STOP_IT_SCORE_EN
    if (w) begin
      if (exp_score < 15) exp_score++;
    end else begin
      exp_score = 0;
    end
`endif
    push(w ? ST_WIN : ST_LOSE, run_dur, stop_at, exp_score);
    push(ST_IDLE, HOLD, stop_at, exp_score);
    @(negedge clk);
    bus.stop_i = 1'b0;
    bus.target_i = 5'(tg);
    @(negedge clk);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    wait_state(ST_RUN, 4);
    if (tg_chg >= 0) bus.target_i = 5'(tg_chg);
    if (stop_at >= 0) begin
      wait_cnt(stop_at, 40);
      bus.stop_i = 1'b1;
      #1 chk("count_en_in_stop_cycle", int'(bus.count_en_o), 0);
    end
    wait_state(w ? ST_WIN : ST_LOSE, 40);
    if (noise) begin
      @(negedge clk) bus.stop_i = 1'b0;
      @(negedge clk) begin bus.start_i = 1'b1; bus.stop_i = 1'b1; end
      @(negedge clk) begin bus.start_i = 1'b0; bus.stop_i = 1'b0; end
    end
    wait_state(ST_IDLE, 20);
    if (noise) begin
      @(negedge clk) bus.stop_i = 1'b1;
      @(negedge clk) bus.stop_i = 1'b0;
      @(negedge clk) bus.stop_i = 1'b1;
      @(negedge clk);
      @(negedge clk);
    end
    @(negedge clk) bus.stop_i = 1'b0;
  endtask

  initial begin
    bus.start_i = 1'b1;
    bus.stop_i = 1'b0;
    bus.target_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_state", int'(bus.state_o), ST_IDLE);
    chk("rst_count_en", int'(bus.count_en_o), 0);
    chk("rst_count_clr_n", int'(bus.count_clr_no), 0);
    chk("rst_win", int'(bus.win_o), 0);
    chk("rst_lose", int'(bus.lose_o), 0);
    chk("rst_score", int'(bus.score_o), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("held_start_no_press", int'(bus.state_o), ST_IDLE);
    chk("idle_clr_asserted", int'(bus.count_clr_no), 0);
    bus.start_i = 1'b0;

    play(5, 5, -1, 0);     // win on exact match
    play(5, 7, -1, 0);     // stop late -> lose, frozen at 7
    play(12, -1, -1, 0);   // timeout at 31
    play(31, 31, -1, 0);   // stop coincides with timeout -> judged win
    play(5, 5, 9, 1);      // latched target; presses during WIN/IDLE ignored
    play(5, 9, 9, 0);      // latched 5, live 9 -> lose
    for (int i = 0; i < 17; i++) play(i % 10 + 2, i % 10 + 2, -1, 0);
    play(4, 6, -1, 0);     // streak broken

    // Asynchronous reset in the middle of RUN.
    push(ST_CLEAR, -1, 0, exp_score);
    push(ST_RUN, 1, 0, exp_score);
    push(ST_IDLE, -1, -1, 0);
    exp_score = 0;
    @(negedge clk) bus.start_i = 1'b1;
    @(negedge clk) bus.start_i = 1'b0;
    wait_state(ST_RUN, 4);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_rst_state", int'(bus.state_o), ST_IDLE);
    chk("midrun_rst_count_en", int'(bus.count_en_o), 0);
    chk("midrun_rst_count_clr_n", int'(bus.count_clr_no), 0);
    chk("midrun_rst_win", int'(bus.win_o), 0);
    chk("midrun_rst_lose", int'(bus.lose_o), 0);
    chk("midrun_rst_score", int'(bus.score_o), 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_count_cleared", int'(cnt), 0);

    play(3, 3, -1, 0);
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end
endmodule
